// File: rtl/flush_drain_ctrl.sv
// Defers a ROB-committed branch flush until every memory port has drained its
// in-flight responses, blocking new issue while the flush waits.
module flush_drain_ctrl #(
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned WAIT_CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_PORTS-1:0]  mem_rqst,
  input  logic [NUM_PORTS-1:0]  mem_resp,
  input  logic                  rob_valid,
  input  logic                  rob_ready,
  input  logic                  flush_branch,
  output logic                  move_flush,
  output logic                  issue_block,
  output logic                  outstanding_any,
  output logic                  proto_err,
  output logic [WAIT_CNT_W-1:0] drain_cycles
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_OUTSTANDING);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q [NUM_PORTS];
  logic [CntW-1:0]       cnt_d [NUM_PORTS];
  logic                  proto_err_q, proto_err_d;
  logic [WAIT_CNT_W-1:0] drain_cycles_q, drain_cycles_d;

  logic flush_req;
  logic drain_ok;
  logic port_err;
  logic any_nonzero;

  assign flush_req = rob_valid & rob_ready & flush_branch;

  // Per-port counters, drain test and protocol checks.
  always_comb begin
    drain_ok    = 1'b1;
    port_err    = 1'b0;
    any_nonzero = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      cnt_d[p] = cnt_q[p];
      if (cnt_q[p] != '0) begin
        any_nonzero = 1'b1;
      end
      // A response this cycle that empties the port still counts as drained;
      // same-cycle requests belong to the post-flush stream and are ignored here.
      if (!((cnt_q[p] == '0 && !mem_resp[p]) || (cnt_q[p] == CntOne && mem_resp[p]))) begin
        drain_ok = 1'b0;
      end
      if (mem_rqst[p] && !mem_resp[p]) begin
        if (cnt_q[p] == CntMax) begin
          port_err = 1'b1;
        end else begin
          cnt_d[p] = cnt_q[p] + CntOne;
        end
      end else if (mem_resp[p] && !mem_rqst[p]) begin
        if (cnt_q[p] == '0) begin
          port_err = 1'b1;
        end else begin
          cnt_d[p] = cnt_q[p] - CntOne;
        end
      end
      if (mem_rqst[p] && issue_block) begin
        port_err = 1'b1;
      end
    end
  end

  assign outstanding_any = any_nonzero;
  assign issue_block     = (state_q == StDrain);
  // Suppressed during reset so a flush cannot escape in the reset cycle.
  assign move_flush      = flush_req & drain_ok & ~rst;
  assign proto_err       = proto_err_q;
  assign drain_cycles    = drain_cycles_q;

  always_comb begin
    state_d        = state_q;
    drain_cycles_d = drain_cycles_q;
    proto_err_d    = proto_err_q | port_err;
    unique case (state_q)
      StIdle: begin
        if (flush_req && !drain_ok) begin
          state_d        = StDrain;
          drain_cycles_d = '0;
        end
      end
      StDrain: begin
        if (drain_cycles_q != '1) begin
          drain_cycles_d = drain_cycles_q + WAIT_CNT_W'(1);
        end
        if (!flush_req || drain_ok) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '{default: '0};
      proto_err_q    <= 1'b0;
      drain_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      proto_err_q    <= proto_err_d;
      drain_cycles_q <= drain_cycles_d;
    end
  end

endmodule
